// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Latency: result in HI/LO and done pulse WIDTH+1 edges after the accepting start edge.
// Backpressure: busy stays high while an operation runs; start and mthi/mtlo are ignored while busy.
//
// Ports: clk/reset (sync, active-high); start/op/a/b launch an operation (sampled only when idle);
// hi_we/lo_we/wdata implement mthi/mtlo; busy/done/div_by_zero report status; hi/lo expose HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [WIDTH-1:0]   a_q, a_d;          // raw dividend, returned in HI on divide-by-zero
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               bz_q, bz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    // Operand magnitudes at acceptance; only signed ops (op[0]=1) look at sign bits.
    logic               in_sa, in_sb;
    logic [WIDTH-1:0]   in_mag_a, in_mag_b;

    // One shift-add step: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole accumulator right by one.
    logic [WIDTH:0]     mul_sum;
    // One restoring step: shift the next dividend bit into the remainder and
    // keep the subtraction only when it does not go negative.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;

    // Sign-corrected results for the FIX state.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        in_sa    = op[0] & a[WIDTH-1];
        in_sb    = op[0] & b[WIDTH-1];
        in_mag_a = in_sa ? -a : a;
        in_mag_b = in_sb ? -b : b;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_b_q : '0)};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mag_b_q};

        prod_fix = (op_q == 2'b01 && (sa_q ^ sb_q)) ? -acc_q : acc_q;
        quot_fix = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        mag_b_d = mag_b_q;
        a_d     = a_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    op_d    = op;
                    sa_d    = in_sa;
                    sb_d    = in_sb;
                    acc_d   = {{WIDTH{1'b0}}, in_mag_a};
                    mag_b_d = in_mag_b;
                    a_d     = a;
                    bz_d    = (b == '0);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (op_q[1]) begin
                    if (div_trial[WIDTH]) begin
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q[1]) begin
                    if (bz_q) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    lo_d = prod_fix[WIDTH-1:0];
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                dbz_d   = op_q[1] & bz_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            mag_b_q <= '0;
            a_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mag_b_q <= mag_b_d;
            a_q     <= a_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle integer multiply/divide unit in the execute stage, alongside the ALU. It takes the same two 32-bit register operands the ALU consumes. It implements MIPS mult/multu/div/divu into dedicated HI/LO registers, which are read by mfhi/mflo and written by mthi/mtlo. Control stalls the pipeline while busy is high.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request operation; accepted only when busy=0
op  input  2  00 multu, 01 mult, 10 divu, 11 div (sampled with start)
a  input  WIDTH  rs operand / dividend (sampled with start)
b  input  WIDTH  rt operand / divisor (sampled with start)
hi_we  input  1  mthi write enable
lo_we  input  1  mtlo write enable
wdata  input  WIDTH  mthi/mtlo data
busy  output  1  operation in progress
done  output  1  one-cycle pulse; HI/LO hold the new result
div_by_zero  output  1  pulses with done when a divide had b=0
hi  output  WIDTH  HI register (mfhi)
lo  output  WIDTH  LO register (mflo)

Behaviour:
- Reset (synchronous, also mid-operation): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. Any in-flight operation is discarded.
- FSM states: IDLE, RUN, FIX. busy = (state != IDLE). done and div_by_zero are registered.
- IDLE:
  - start=1 at edge k: latch op, operand magnitudes and signs (signed ops only), counter=0, go to RUN.
  - start=0: stay in IDLE.
- RUN: one iteration per edge, at edges k+1..k+WIDTH. On the edge where counter=WIDTH-1, go to FIX.
- FIX: at edge k+WIDTH+1, apply sign correction, write HI/LO, set done=1, return to IDLE.
  - Latency: done is high in the cycle after edge k+WIDTH+1 (33 edges after the start edge for WIDTH=32).
  - done stays high for exactly one cycle.
- Multiply: shift-add on magnitudes, producing a 2*WIDTH-bit product. HI = upper half, LO = lower half.
  - mult: negate the 64-bit product if the operand signs differ.
- Divide: restoring shift-subtract on magnitudes. LO = quotient, HI = remainder.
  - div: quotient is negative if signs differ; remainder takes the sign of the dividend.
  - div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (b=0, op 10/11): full latency still runs. LO=all ones, HI=a (as latched), div_by_zero=1 alongside done.
- start while busy=1 is ignored, with no effect on the in-flight operation.
- start in the done cycle is legal (busy=0 then).
- Operand changes on a/b/op after acceptance have no effect.
- hi_we/lo_we:
  - Applied at the clock edge only when busy=0; ignored while busy.
  - If asserted in the same cycle as an accepted start, the write is applied; the later result overwrites it.
  - If hi_we and lo_we are both set, both registers get wdata.
- HI/LO hold their value between operations. Multiply-only and divide-only results never leave a stale half (both halves are always written).

Test Plan:
1. Reset, then multu a=30 b=21 → busy high for 33 edges; done pulses once; lo=630, hi=0; div_by_zero=0.
2. mult a=0xFFFFFFFD (-3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then multu 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
3. div a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu 100/7 → lo=14, hi=2. Then div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. divu a=9 b=0 → done after 33 edges with div_by_zero=1; lo=0xFFFFFFFF, hi=9.
5. Start multu 6*7. At edge k+5, assert start with a=1 b=1 plus hi_we with wdata=0x55 → both ignored; result hi=0, lo=42. Then hi_we wdata=0x55 with busy=0 → hi=0x55.
6. Start divu 100/7; assert reset at edge k+10 → next cycle busy=0, done=0, hi=lo=0. No done pulse follows; a new start works normally.
